// File: rtl/gl_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// gl_cmd_sequencer
//   Takes one GL opcode/immediate per valid/ready handshake from instruction
//   fetch. Turns it into registered control pulses for the matrix stack,
//   matrix multiplier, perspective divider, BRAM reader, viewport and colour
//   registers. Multi-cycle commands wait on parameterised datapath latencies.
//   A stack depth is kept for each matrix mode so that push-at-full and
//   pop-at-empty are flagged instead of being issued.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready only while idle
//   opcode, imm          command opcode and immediate (imm[0] = matrix mode)
//   color_in             colour operand for COLOR
//   bram_addr_in         base address operand for LOADMATRIX / VIEWPORT
//   bram_addr_out        BRAM read address
//   bram_rd_en           BRAM read strobe (data returns one cycle later)
//   bram_rd_data         {w3,w2,w1,w0} read word
//   viewport_*           viewport registers (IEEE float)
//   color_out            current colour
//   push_en/pop_en       stack push / pop pulses
//   load_en, load_row    matrix row-load pulse and row index
//   load_id_en           load-identity pulse
//   mul_en, mul_type     multiply start pulse; 1 = 4x4*4x4, 0 = 4x4*4x1
//   matrix_mode_out      target matrix: 1 = modelview, 0 = projection
//   pdiv_en              perspective-divide start pulse
//   err_stack            push-at-full / pop-at-empty pulse
//   err_illegal          unknown-opcode pulse
// ---------------------------------------------------------------------------
module gl_cmd_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ROW_STRIDE  = 16,
  parameter int MAT_ROWS    = 4,
  parameter int MUL_LAT     = 4,
  parameter int PDIV_LAT    = 1,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            opcode,
  input  logic [22:0]           imm,
  input  logic [DATA_W-1:0]     color_in,
  input  logic [ADDR_W-1:0]     bram_addr_in,
  output logic [ADDR_W-1:0]     bram_addr_out,
  output logic                  bram_rd_en,
  input  logic [4*DATA_W-1:0]   bram_rd_data,
  output logic [DATA_W-1:0]     viewport_min_x,
  output logic [DATA_W-1:0]     viewport_min_y,
  output logic [DATA_W-1:0]     viewport_max_x,
  output logic [DATA_W-1:0]     viewport_max_y,
  output logic [DATA_W-1:0]     color_out,
  output logic                  push_en,
  output logic                  pop_en,
  output logic                  load_en,
  output logic [2:0]            load_row,
  output logic                  load_id_en,
  output logic                  mul_en,
  output logic                  mul_type,
  output logic                  matrix_mode_out,
  output logic                  pdiv_en,
  output logic                  err_stack,
  output logic                  err_illegal
);

  localparam int DEPTH_W = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;
  localparam int LAT_W   = 16;
  localparam int ROW_W   = 4;

  localparam logic [7:0] OP_BEGIN      = 8'h01;
  localparam logic [7:0] OP_END        = 8'h02;
  localparam logic [7:0] OP_VERTEX     = 8'h03;
  localparam logic [7:0] OP_COLOR      = 8'h04;
  localparam logic [7:0] OP_MATRIXMODE = 8'h10;
  localparam logic [7:0] OP_MULT       = 8'h11;
  localparam logic [7:0] OP_LOADID     = 8'h12;
  localparam logic [7:0] OP_LOADMATRIX = 8'h13;
  localparam logic [7:0] OP_PUSH       = 8'h14;
  localparam logic [7:0] OP_POP        = 8'h15;
  localparam logic [7:0] OP_ROTATE     = 8'h16;
  localparam logic [7:0] OP_SCALE      = 8'h17;
  localparam logic [7:0] OP_TRANSLATE  = 8'h18;
  localparam logic [7:0] OP_VIEWPORT   = 8'h19;
  localparam logic [7:0] OP_FRUSTUM    = 8'h1A;

  localparam logic [DATA_W-1:0] VP_MAX_X_RST = DATA_W'(32'h4420_0000);
  localparam logic [DATA_W-1:0] VP_MAX_Y_RST = DATA_W'(32'h43F0_0000);

  typedef enum logic [2:0] {
    IDLE,
    VTX_MV,
    VTX_PJ,
    VTX_PD,
    MUL,
    LOAD,
    VPRT
  } state_t;

  state_t              state, state_nxt;
  logic [LAT_W-1:0]    lat_cnt, lat_cnt_nxt;
  logic [ROW_W-1:0]    rd_cnt, rd_cnt_nxt;
  logic [ROW_W-1:0]    ld_cnt, ld_cnt_nxt;
  logic                curr_mode, curr_mode_nxt;
  logic [DEPTH_W-1:0]  depth_mv, depth_mv_nxt;
  logic [DEPTH_W-1:0]  depth_pj, depth_pj_nxt;
  logic [DEPTH_W-1:0]  depth_cur;
  logic                vp_pending, vp_pending_nxt;

  logic [ADDR_W-1:0]   bram_addr_nxt;
  logic                bram_rd_en_nxt;
  logic [DATA_W-1:0]   vp_min_x_nxt, vp_min_y_nxt, vp_max_x_nxt, vp_max_y_nxt;
  logic [DATA_W-1:0]   color_nxt;
  logic                push_nxt, pop_nxt, load_nxt, load_id_nxt, mul_nxt, pdiv_nxt;
  logic [2:0]          load_row_nxt;
  logic                mul_type_nxt, mode_out_nxt;
  logic                err_stack_nxt, err_illegal_nxt;

  // Only imm[0] carries meaning today; the rest is reserved.
  logic unused_imm;
  assign unused_imm = ^imm[22:1];

  assign cmd_ready = (state == IDLE);

  // Depth of the stack the current matrix mode points at (1 = modelview).
  assign depth_cur = curr_mode ? depth_mv : depth_pj;

  // Next-state and next-output logic. Pulses default low and held
  // outputs default to their current value, so each branch only names
  // what it changes.
  always_comb begin
    state_nxt       = state;
    lat_cnt_nxt     = lat_cnt;
    rd_cnt_nxt      = rd_cnt;
    ld_cnt_nxt      = ld_cnt;
    curr_mode_nxt   = curr_mode;
    depth_mv_nxt    = depth_mv;
    depth_pj_nxt    = depth_pj;
    vp_pending_nxt  = 1'b0;
    bram_addr_nxt   = bram_addr_out;
    bram_rd_en_nxt  = 1'b0;
    vp_min_x_nxt    = viewport_min_x;
    vp_min_y_nxt    = viewport_min_y;
    vp_max_x_nxt    = viewport_max_x;
    vp_max_y_nxt    = viewport_max_y;
    color_nxt       = color_out;
    push_nxt        = 1'b0;
    pop_nxt         = 1'b0;
    load_nxt        = 1'b0;
    load_row_nxt    = load_row;
    load_id_nxt     = 1'b0;
    mul_nxt         = 1'b0;
    pdiv_nxt        = 1'b0;
    mul_type_nxt    = mul_type;
    mode_out_nxt    = matrix_mode_out;
    err_stack_nxt   = 1'b0;
    err_illegal_nxt = 1'b0;

    // The viewport word arrives the cycle after the VPRT read strobe,
    // by which time the FSM is already back in IDLE.
    if (vp_pending) begin
      vp_min_x_nxt = bram_rd_data[DATA_W-1:0];
      vp_min_y_nxt = bram_rd_data[2*DATA_W-1:DATA_W];
      vp_max_x_nxt = bram_rd_data[3*DATA_W-1:2*DATA_W];
      vp_max_y_nxt = bram_rd_data[4*DATA_W-1:3*DATA_W];
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (opcode)
            OP_BEGIN, OP_END, OP_FRUSTUM: begin
            end
            OP_COLOR: begin
              color_nxt = color_in;
            end
            OP_MATRIXMODE: begin
              curr_mode_nxt = imm[0];
            end
            OP_LOADID: begin
              load_id_nxt  = 1'b1;
              mode_out_nxt = curr_mode;
            end
            OP_PUSH: begin
              mode_out_nxt = curr_mode;
              if (depth_cur == DEPTH_W'(STACK_DEPTH - 1)) begin
                err_stack_nxt = 1'b1;
              end else begin
                push_nxt = 1'b1;
                if (curr_mode) depth_mv_nxt = depth_mv + DEPTH_W'(1);
                else           depth_pj_nxt = depth_pj + DEPTH_W'(1);
              end
            end
            OP_POP: begin
              mode_out_nxt = curr_mode;
              if (depth_cur == '0) begin
                err_stack_nxt = 1'b1;
              end else begin
                pop_nxt = 1'b1;
                if (curr_mode) depth_mv_nxt = depth_mv - DEPTH_W'(1);
                else           depth_pj_nxt = depth_pj - DEPTH_W'(1);
              end
            end
            OP_VERTEX: begin
              // Modelview transform first, then projection, then divide.
              mul_nxt      = 1'b1;
              mul_type_nxt = 1'b0;
              mode_out_nxt = 1'b1;
              lat_cnt_nxt  = LAT_W'(MUL_LAT - 1);
              state_nxt    = VTX_MV;
            end
            OP_MULT, OP_ROTATE, OP_SCALE, OP_TRANSLATE: begin
              mul_nxt      = 1'b1;
              mul_type_nxt = 1'b1;
              mode_out_nxt = curr_mode;
              lat_cnt_nxt  = LAT_W'(MUL_LAT - 1);
              state_nxt    = MUL;
            end
            OP_LOADMATRIX: begin
              bram_rd_en_nxt = 1'b1;
              bram_addr_nxt  = bram_addr_in;
              rd_cnt_nxt     = ROW_W'(1);
              ld_cnt_nxt     = '0;
              mode_out_nxt   = curr_mode;
              state_nxt      = LOAD;
            end
            OP_VIEWPORT: begin
              bram_rd_en_nxt = 1'b1;
              bram_addr_nxt  = bram_addr_in;
              state_nxt      = VPRT;
            end
            default: begin
              err_illegal_nxt = 1'b1;
            end
          endcase
        end
      end

      VTX_MV: begin
        if (lat_cnt == '0) begin
          mul_nxt      = 1'b1;
          mode_out_nxt = 1'b0;
          lat_cnt_nxt  = LAT_W'(PDIV_LAT - 1);
          lat_cnt_nxt  = LAT_W'(MUL_LAT - 1);
          state_nxt    = VTX_PJ;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end

      VTX_PJ: begin
        if (lat_cnt == '0) begin
          pdiv_nxt    = 1'b1;
          lat_cnt_nxt = LAT_W'(PDIV_LAT - 1);
          state_nxt   = VTX_PD;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end

      VTX_PD, MUL: begin
        if (lat_cnt == '0) state_nxt = IDLE;
        else               lat_cnt_nxt = lat_cnt - LAT_W'(1);
      end

      LOAD: begin
        // Reads run one row ahead of loads: each load_en lines up with the
        // BRAM data of the read strobed in the previous cycle.
        if (rd_cnt < ROW_W'(MAT_ROWS)) begin
          bram_rd_en_nxt = 1'b1;
          bram_addr_nxt  = bram_addr_out + ADDR_W'(ROW_STRIDE);
          rd_cnt_nxt     = rd_cnt + ROW_W'(1);
        end
        if (bram_rd_en) begin
          load_nxt     = 1'b1;
          load_row_nxt = ld_cnt[2:0];
          ld_cnt_nxt   = ld_cnt + ROW_W'(1);
        end
        if (ld_cnt == ROW_W'(MAT_ROWS)) state_nxt = IDLE;
      end

      VPRT: begin
        vp_pending_nxt = 1'b1;
        state_nxt      = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      rd_cnt          <= '0;
      ld_cnt          <= '0;
      curr_mode       <= 1'b0;
      depth_mv        <= '0;
      depth_pj        <= '0;
      vp_pending      <= 1'b0;
      bram_addr_out   <= '0;
      bram_rd_en      <= 1'b0;
      viewport_min_x  <= '0;
      viewport_min_y  <= '0;
      viewport_max_x  <= VP_MAX_X_RST;
      viewport_max_y  <= VP_MAX_Y_RST;
      color_out       <= '0;
      push_en         <= 1'b0;
      pop_en          <= 1'b0;
      load_en         <= 1'b0;
      load_row        <= '0;
      load_id_en      <= 1'b0;
      mul_en          <= 1'b0;
      mul_type        <= 1'b0;
      matrix_mode_out <= 1'b0;
      pdiv_en         <= 1'b0;
      err_stack       <= 1'b0;
      err_illegal     <= 1'b0;
    end else begin
      state           <= state_nxt;
      lat_cnt         <= lat_cnt_nxt;
      rd_cnt          <= rd_cnt_nxt;
      ld_cnt          <= ld_cnt_nxt;
      curr_mode       <= curr_mode_nxt;
      depth_mv        <= depth_mv_nxt;
      depth_pj        <= depth_pj_nxt;
      vp_pending      <= vp_pending_nxt;
      bram_addr_out   <= bram_addr_nxt;
      bram_rd_en      <= bram_rd_en_nxt;
      viewport_min_x  <= vp_min_x_nxt;
      viewport_min_y  <= vp_min_y_nxt;
      viewport_max_x  <= vp_max_x_nxt;
      viewport_max_y  <= vp_max_y_nxt;
      color_out       <= color_nxt;
      push_en         <= push_nxt;
      pop_en          <= pop_nxt;
      load_en         <= load_nxt;
      load_row        <= load_row_nxt;
      load_id_en      <= load_id_nxt;
      mul_en          <= mul_nxt;
      mul_type        <= mul_type_nxt;
      matrix_mode_out <= mode_out_nxt;
      pdiv_en         <= pdiv_nxt;
      err_stack       <= err_stack_nxt;
      err_illegal     <= err_illegal_nxt;
    end
  end

endmodule

// File: tb/tb_gl_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gl_cmd_sequencer
//   Scoreboard bench for gl_cmd_sequencer. Every accepted command pushes
//   the pulses it should cause, tagged with the clock edge they are
//   registered on, into a queue. A negedge monitor pops and compares them
//   whenever a pulse appears or an expected pulse falls due. Held
//   registers and handshake timing are compared against a small model.
// ---------------------------------------------------------------------------
module tb_gl_cmd_sequencer;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int ROW_STRIDE  = 16;
  localparam int MAT_ROWS    = 4;
  localparam int MUL_LAT     = 4;
  localparam int PDIV_LAT    = 1;
  localparam int STACK_DEPTH = 8;

  localparam logic [8:0] B_PUSH   = 9'h001;
  localparam logic [8:0] B_POP    = 9'h002;
  localparam logic [8:0] B_LOAD   = 9'h004;
  localparam logic [8:0] B_LOADID = 9'h008;
  localparam logic [8:0] B_MUL    = 9'h010;
  localparam logic [8:0] B_PDIV   = 9'h020;
  localparam logic [8:0] B_ERRS   = 9'h040;
  localparam logic [8:0] B_ILL    = 9'h080;
  localparam logic [8:0] B_RD     = 9'h100;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [7:0]           opcode = '0;
  logic [22:0]          imm = '0;
  logic [DATA_W-1:0]    color_in = '0;
  logic [ADDR_W-1:0]    bram_addr_in = '0;
  logic [ADDR_W-1:0]    bram_addr_out;
  logic                 bram_rd_en;
  logic [4*DATA_W-1:0]  bram_rd_data = '0;
  logic [DATA_W-1:0]    viewport_min_x, viewport_min_y, viewport_max_x, viewport_max_y;
  logic [DATA_W-1:0]    color_out;
  logic                 push_en, pop_en, load_en, load_id_en, mul_en, mul_type;
  logic [2:0]           load_row;
  logic                 matrix_mode_out, pdiv_en, err_stack, err_illegal;

  gl_cmd_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_STRIDE(ROW_STRIDE), .MAT_ROWS(MAT_ROWS),
    .MUL_LAT(MUL_LAT), .PDIV_LAT(PDIV_LAT), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .opcode(opcode), .imm(imm), .color_in(color_in), .bram_addr_in(bram_addr_in),
    .bram_addr_out(bram_addr_out), .bram_rd_en(bram_rd_en), .bram_rd_data(bram_rd_data),
    .viewport_min_x(viewport_min_x), .viewport_min_y(viewport_min_y),
    .viewport_max_x(viewport_max_x), .viewport_max_y(viewport_max_y),
    .color_out(color_out), .push_en(push_en), .pop_en(pop_en), .load_en(load_en),
    .load_row(load_row), .load_id_en(load_id_en), .mul_en(mul_en), .mul_type(mul_type),
    .matrix_mode_out(matrix_mode_out), .pdiv_en(pdiv_en), .err_stack(err_stack),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the index of the last rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at_edge;
    logic [8:0]  mask;
    logic [31:0] addr;
    logic [2:0]  row;
    logic        mode;
    logic        mtype;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic        m_mode;
  int          m_depth[2];
  logic [31:0] m_color;
  logic [31:0] m_vp[4];
  int          m_ready_edge;

  function automatic logic [31:0] bramWord(input logic [31:0] a, input int i);
    return a ^ (32'h3F80_0000 + 32'(i) * 32'h0101_0101);
  endfunction

  // Synchronous BRAM: data for an address strobed in one cycle is
  // visible in the next.
  always @(posedge clk) begin
    if (bram_rd_en)
      bram_rd_data <= {bramWord(bram_addr_out, 3), bramWord(bram_addr_out, 2),
                       bramWord(bram_addr_out, 1), bramWord(bram_addr_out, 0)};
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic addItem(input int at, input logic [8:0] bits, input logic [31:0] addr,
                         input logic [2:0] row, input logic mode, input logic mtype);
    exp_t e;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].at_edge == at) begin
      e = exp_q.pop_back();
    end else begin
      e.at_edge = at;
      e.mask = '0;
      e.addr = '0;
      e.row = '0;
      e.mode = 1'b0;
      e.mtype = 1'b0;
    end
    e.mask = e.mask | bits;
    if (bits[8]) e.addr = addr;
    if (bits[2]) e.row = row;
    if ((bits & (B_LOAD | B_LOADID | B_MUL)) != '0) e.mode = mode;
    if (bits[4]) e.mtype = mtype;
    exp_q.push_back(e);
  endtask

  task automatic resetModel();
    m_mode = 1'b0;
    m_depth[0] = 0;
    m_depth[1] = 0;
    m_color = '0;
    m_vp[0] = '0;
    m_vp[1] = '0;
    m_vp[2] = 32'h4420_0000;
    m_vp[3] = 32'h43F0_0000;
    m_ready_edge = 0;
  endtask

  // Pulse monitor.
  logic [8:0] obs_mask;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      obs_mask = {bram_rd_en, err_illegal, err_stack, pdiv_en, mul_en,
                  load_id_en, load_en, pop_en, push_en};
      if (obs_mask != '0 || (exp_q.size() > 0 && exp_q[0].at_edge <= cyc)) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", 64'(obs_mask), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("pulse_edge", 64'(cyc), 64'(mon_e.at_edge));
          checkOutput("pulse_mask", 64'(obs_mask), 64'(mon_e.mask));
          if (mon_e.mask[8]) checkOutput("bram_addr", 64'(bram_addr_out), 64'(mon_e.addr));
          if (mon_e.mask[2]) checkOutput("load_row", 64'(load_row), 64'(mon_e.row));
          if ((mon_e.mask & (B_LOAD | B_LOADID | B_MUL)) != '0)
            checkOutput("matrix_mode", 64'(matrix_mode_out), 64'(mon_e.mode));
          if (mon_e.mask[4]) checkOutput("mul_type", 64'(mul_type), 64'(mon_e.mtype));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkRegs();
    @(negedge clk);
    checkOutput("cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("color_out", 64'(color_out), 64'(m_color));
    checkOutput("vp_min_x", 64'(viewport_min_x), 64'(m_vp[0]));
    checkOutput("vp_min_y", 64'(viewport_min_y), 64'(m_vp[1]));
    checkOutput("vp_max_x", 64'(viewport_max_x), 64'(m_vp[2]));
    checkOutput("vp_max_y", 64'(viewport_max_y), 64'(m_vp[3]));
  endtask

  // Drive one command as soon as the DUT is ready, check the accept edge
  // against the model, and queue the pulses it should produce.
  task automatic applyStimulus(input logic [7:0] op, input logic [22:0] im,
                               input logic [31:0] col, input logic [31:0] base);
    int first;
    int waited;
    int t;
    int m;
    @(negedge clk);
    first = cyc + 1;
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("ready_timeout", 64'd0, 64'd1);
      return;
    end
    t = cyc + 1;
    checkOutput("accept_edge", 64'(t), 64'((m_ready_edge > first) ? m_ready_edge : first));
    opcode = op;
    imm = im;
    color_in = col;
    bram_addr_in = base;
    cmd_valid = 1'b1;

    m = m_mode ? 1 : 0;
    m_ready_edge = t + 1;
    case (op)
      8'h01, 8'h02, 8'h1A: begin
      end
      8'h04: m_color = col;
      8'h10: m_mode = im[0];
      8'h12: addItem(t, B_LOADID, '0, '0, m_mode, 1'b0);
      8'h14: begin
        if (m_depth[m] == STACK_DEPTH - 1) addItem(t, B_ERRS, '0, '0, 1'b0, 1'b0);
        else begin
          addItem(t, B_PUSH, '0, '0, 1'b0, 1'b0);
          m_depth[m]++;
        end
      end
      8'h15: begin
        if (m_depth[m] == 0) addItem(t, B_ERRS, '0, '0, 1'b0, 1'b0);
        else begin
          addItem(t, B_POP, '0, '0, 1'b0, 1'b0);
          m_depth[m]--;
        end
      end
      8'h03: begin
        addItem(t, B_MUL, '0, '0, 1'b1, 1'b0);
        addItem(t + MUL_LAT, B_MUL, '0, '0, 1'b0, 1'b0);
        addItem(t + 2*MUL_LAT, B_PDIV, '0, '0, 1'b0, 1'b0);
        m_ready_edge = t + 1 + 2*MUL_LAT + PDIV_LAT;
      end
      8'h11, 8'h16, 8'h17, 8'h18: begin
        addItem(t, B_MUL, '0, '0, m_mode, 1'b1);
        m_ready_edge = t + 1 + MUL_LAT;
      end
      8'h13: begin
        for (int r = 0; r < MAT_ROWS; r++) begin
          addItem(t + r, B_RD, base + 32'(r * ROW_STRIDE), '0, 1'b0, 1'b0);
          addItem(t + 1 + r, B_LOAD, '0, 3'(r), m_mode, 1'b0);
        end
        m_ready_edge = t + 2 + MAT_ROWS;
      end
      8'h19: begin
        addItem(t, B_RD, base, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) m_vp[i] = bramWord(base, i);
        m_ready_edge = t + 2;
      end
      default: addItem(t, B_ILL, '0, '0, 1'b0, 1'b0);
    endcase

    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    opcode = 8'($urandom);
    imm = 23'($urandom);
    color_in = $urandom;
    bram_addr_in = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got %0d vectors, expected completion", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetModel();

    // Reset values.
    idle(3);
    checkOutput("ready_in_reset", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;
    checkRegs();
    checkOutput("mode_out_rst", 64'(matrix_mode_out), 64'd0);
    checkOutput("mul_type_rst", 64'(mul_type), 64'd0);

    // VERTEX pipeline timing.
    applyStimulus(8'h03, '0, '0, '0);

    // LOADMATRIX in modelview, then in projection with address wrap.
    applyStimulus(8'h10, 23'h1, '0, '0);
    applyStimulus(8'h13, '0, '0, 32'h0000_0100);
    applyStimulus(8'h10, 23'h2, '0, '0);
    applyStimulus(8'h13, '0, '0, 32'hFFFF_FFE0);

    // Identity and multiplies in both modes.
    applyStimulus(8'h12, '0, '0, '0);
    applyStimulus(8'h11, '0, '0, '0);
    applyStimulus(8'h10, 23'h7F_FFFF, '0, '0);
    applyStimulus(8'h16, '0, '0, '0);
    applyStimulus(8'h17, '0, '0, '0);
    applyStimulus(8'h18, '0, '0, '0);
    applyStimulus(8'h12, '0, '0, '0);

    // Modelview stack: fill past full, then drain past empty.
    for (int i = 0; i < 8; i++) applyStimulus(8'h14, '0, '0, '0);
    for (int i = 0; i < 8; i++) applyStimulus(8'h15, '0, '0, '0);

    // Illegal opcodes, no-ops and back-to-back colour.
    applyStimulus(8'hFF, '0, '0, '0);
    applyStimulus(8'h04, '0, 32'h00FF_00FF, '0);
    applyStimulus(8'h00, '0, '0, '0);
    applyStimulus(8'h1B, '0, '0, '0);
    applyStimulus(8'h01, '0, '0, '0);
    applyStimulus(8'h1A, '0, '0, '0);
    applyStimulus(8'h02, '0, '0, '0);
    idle(2);
    checkRegs();

    // Viewport load, then colour immediately after.
    applyStimulus(8'h19, '0, '0, 32'h0000_2000);
    applyStimulus(8'h04, '0, 32'hDEAD_BEEF, '0);
    idle(3);
    checkRegs();

    // Reset during a VERTEX with non-empty stacks.
    applyStimulus(8'h10, 23'h1, '0, '0);
    applyStimulus(8'h14, '0, '0, '0);
    applyStimulus(8'h14, '0, '0, '0);
    applyStimulus(8'h10, 23'h0, '0, '0);
    applyStimulus(8'h14, '0, '0, '0);
    applyStimulus(8'h03, '0, '0, '0);
    idle(3);
    rst_n = 1'b0;
    exp_q.delete();
    resetModel();
    idle(3);
    rst_n = 1'b1;
    checkRegs();
    idle(2 * MUL_LAT + PDIV_LAT + 2);
    applyStimulus(8'h15, '0, '0, '0);
    applyStimulus(8'h10, 23'h1, '0, '0);
    applyStimulus(8'h15, '0, '0, '0);
    applyStimulus(8'h14, '0, '0, '0);

    idle(20);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
